// File: rtl/and_stage_pkg.sv
// ---------------------------------------------------------------------------
// and_stage_pkg
// Shared definitions for the 8-bit AND unit front end.
//   OPERAND_W  : operand / data-bus width
//   CNT_W      : width of the completed-pair counter
//   ld_state_t : operand loader FSM state codes
//   ST_*       : the same codes as plain 2-bit constants, for state
//                registers that must also be able to hold the illegal
//                code 2'b11
// ---------------------------------------------------------------------------
package and_stage_pkg;

  localparam int OPERAND_W = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    PRESENT = 2'b10
  } ld_state_t;

  localparam logic [1:0] ST_LOAD_A  = LOAD_A;
  localparam logic [1:0] ST_LOAD_B  = LOAD_B;
  localparam logic [1:0] ST_PRESENT = PRESENT;

endpackage : and_stage_pkg

// File: rtl/and_operand_loader_strobe_sync.sv
// ---------------------------------------------------------------------------
// strobe_sync
// Brings an asynchronous pin strobe into the clk domain and emits a
// one-cycle pulse per rising edge of the strobe.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   async_in   : asynchronous strobe from a pin
//   rise_pulse : registered, one clk cycle high per rising edge of async_in
// Latency: rise_pulse is high during the cycle that ends on the
// (SYNC_STAGES+2)th rising clk edge after async_in rises, so a consumer
// acting on it updates on that edge. SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   pulse_q;
  logic                   pulse_d;

  // Synchronizer chain: stage 0 may go metastable, later stages settle it.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= async_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // Edge detect against the previous synchronized level; the pulse itself
  // is registered so downstream logic sees a clean flop output.
  always_comb begin
    pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      edge_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= pulse_d;
    end
  end

  assign rise_pulse = pulse_q;

endmodule : strobe_sync

// File: rtl/and_operand_loader.sv
// ---------------------------------------------------------------------------
// and_operand_loader
// Captures operand A then operand B from one shared pin bus, each load
// triggered by a rising edge on an asynchronous strobe pin, then offers the
// pair to the AND unit with a valid/ready handshake.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : shared operand bus (stable while in_strobe is high)
//   in_strobe  : asynchronous load strobe, rising edge loads one operand
//   clr        : synchronous clear, beats loads and handshakes
//   a_out      : operand A
//   b_out      : operand B
//   pair_valid : A/B pair complete and stable
//   pair_ready : consumer accepts the pair
//   op_count   : completed-handshake counter (wraps)
//   overrun    : sticky, a load arrived while a pair was pending
//   state_out  : FSM state code for debug pins
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module and_operand_loader
  import and_stage_pkg::*;
#(
  parameter int WIDTH       = OPERAND_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_strobe,
  input  logic             clr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [CNT_W-1:0] op_count,
  output logic             overrun,
  output logic [1:0]       state_out
);

  logic             load_pulse;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic             valid_q,   valid_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             overrun_q, overrun_d;

  strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (in_strobe),
    .rise_pulse (load_pulse)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (clr) begin
      // Clear wipes the pair and the flag but keeps the running count.
      state_d   = ST_LOAD_A;
      valid_d   = 1'b0;
      a_d       = '0;
      b_d       = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (load_pulse) begin
            a_d     = in_data;
            state_d = ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (load_pulse) begin
            b_d     = in_data;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // A load here has nowhere to go: drop it and remember that.
          // The handshake is independent and may complete on the same edge.
          if (load_pulse) begin
            overrun_d = 1'b1;
          end
          if (valid_q && pair_ready) begin
            valid_d = 1'b0;
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = ST_LOAD_A;
          end
        end
        default: begin
          // Illegal code: recover without touching any output register.
          state_d = ST_LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign pair_valid = valid_q;
  assign op_count   = count_q;
  assign overrun    = overrun_q;
  assign state_out  = state_q;

endmodule : and_operand_loader

// File: tb/tb_and_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_and_operand_loader
// Directed and randomized stimulus for and_operand_loader, checked against a
// behavioural model that tracks how many operands are held (0, 1 or 2),
// the operand values, the pair count and the overrun flag.
// ---------------------------------------------------------------------------
module tb_and_operand_loader;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk;
  logic         clk_en;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_strobe;
  logic         clr;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         pair_valid;
  logic         pair_ready;
  logic [7:0]   op_count;
  logic         overrun;
  logic [1:0]   state_out;

  int n_cmp = 0;
  int n_err = 0;

  // Model: number of operands held plus the visible values.
  int m_held;
  int m_a, m_b, m_valid, m_count, m_overrun;

  and_operand_loader #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .clr        (clr),
    .a_out      (a_out),
    .b_out      (b_out),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .op_count   (op_count),
    .overrun    (overrun),
    .state_out  (state_out)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_state();
    if (m_held == 0) return 0;
    if (m_held == 1) return 1;
    return 2;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".a"},       int'(a_out),      m_a);
    chk({tag, ".b"},       int'(b_out),      m_b);
    chk({tag, ".valid"},   int'(pair_valid), m_valid);
    chk({tag, ".count"},   int'(op_count),   m_count);
    chk({tag, ".overrun"}, int'(overrun),    m_overrun);
    chk({tag, ".state"},   int'(state_out),  exp_state());
  endtask

  task automatic model_clear();
    m_held = 0; m_a = 0; m_b = 0; m_valid = 0; m_overrun = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_count = 0;
  endtask

  task automatic model_load(input int d);
    if (m_held == 0) begin
      m_a = d; m_held = 1;
    end else if (m_held == 1) begin
      m_b = d; m_valid = 1; m_held = 2;
    end else begin
      m_overrun = 1;
    end
  endtask

  task automatic model_accept();
    m_valid = 0;
    m_count = (m_count + 1) % 256;
    m_held  = 0;
  endtask

  // One legal strobe; optionally assert pair_ready or clr for the edge on
  // which the operand is captured.
  task automatic strobe(input logic [7:0] d, input bit rdy, input bit clr_at);
    bit was_full;
    @(negedge clk);
    in_data   = d;
    in_strobe = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 chk_all("pre_load");
    @(negedge clk);
    pair_ready = rdy;
    clr        = clr_at;
    @(posedge clk);
    was_full = (m_held == 2);
    if (clr_at) model_clear();
    else begin
      model_load(int'(d));
      if (rdy && was_full) model_accept();
    end
    #1 chk_all("load");
    $display("load d=%02h rdy=%0d clr=%0d -> a=%02h b=%02h v=%0d cnt=%0d ovr=%0d st=%0d",
             d, rdy, clr_at, a_out, b_out, pair_valid, op_count, overrun, state_out);
    @(negedge clk);
    pair_ready = 1'b0;
    clr        = 1'b0;
    @(negedge clk);
    in_strobe = 1'b0;
    in_data   = W'($urandom);
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic handshake();
    @(negedge clk);
    pair_ready = 1'b1;
    @(posedge clk);
    if (m_held == 2) model_accept();
    #1 chk_all("handshake");
    $display("handshake -> v=%0d cnt=%0d st=%0d", pair_valid, op_count, state_out);
    @(negedge clk);
    pair_ready = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    model_clear();
    #1 chk_all("clr");
    $display("clr -> a=%02h b=%02h st=%0d cnt=%0d", a_out, b_out, state_out, op_count);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Asynchronous reset with the clock stopped at its low phase.
  task automatic async_reset(input string tag);
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all(tag);
    $display("%s -> a=%02h b=%02h v=%0d cnt=%0d st=%0d", tag, a_out, b_out, pair_valid,
             op_count, state_out);
    #1 rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clk        = 1'b0;
    clk_en     = 1'b1;
    rst_n      = 1'b0;
    in_data    = W'($urandom);
    in_strobe  = 1'($urandom);
    clr        = 1'($urandom);
    pair_ready = 1'($urandom);
    model_reset();

    // Reset held with random input activity.
    repeat (4) begin
      @(negedge clk);
      in_data    = W'($urandom);
      in_strobe  = 1'($urandom);
      clr        = 1'($urandom);
      pair_ready = 1'($urandom);
    end
    @(negedge clk);
    in_strobe  = 1'b0;
    clr        = 1'b0;
    pair_ready = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("reset");
    $display("reset -> a=%02h b=%02h v=%0d cnt=%0d st=%0d", a_out, b_out, pair_valid,
             op_count, state_out);

    // Basic load and handshake.
    strobe(8'hF0, 1'b0, 1'b0);
    strobe(8'h3C, 1'b0, 1'b0);
    chk("basic.a", int'(a_out), 'hF0);
    chk("basic.b", int'(b_out), 'h3C);
    handshake();
    chk("basic.count", int'(op_count), 1);

    // Backpressure and overrun.
    strobe(8'h11, 1'b0, 1'b0);
    strobe(8'h22, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_all("hold");
    strobe(8'hAA, 1'b0, 1'b0);
    chk("ovr.flag", int'(overrun), 1);
    handshake();
    chk("ovr.sticky", int'(overrun), 1);

    // Overrun load coinciding with the handshake edge.
    do_clr();
    strobe(8'h5A, 1'b0, 1'b0);
    strobe(8'hA5, 1'b0, 1'b0);
    strobe(8'hC3, 1'b1, 1'b0);

    // clr beats a load in LOAD_B.
    strobe(8'h55, 1'b0, 1'b0);
    strobe(8'h66, 1'b0, 1'b1);
    chk("clr.state", int'(state_out), 0);

    // Glitch that straddles no clock edge, then a legal strobe.
    @(negedge clk);
    #1 in_data = 8'h7E;
    in_strobe = 1'b1;
    #3 in_strobe = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    chk_all("glitch");
    strobe(8'h81, 1'b0, 1'b0);
    chk("glitch.a", int'(a_out), 'h81);

    // Reset mid-operation with the clock stopped.
    async_reset("reset_mid");

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int sel;
      strobe(W'($urandom), 1'b0, 1'b0);
      strobe(W'($urandom), 1'b0, 1'b0);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        strobe(W'($urandom), 1'($urandom), 1'b0);
      end else if (sel == 1) begin
        do_clr();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end

    // Counter wrap.
    async_reset("reset_wrap");
    for (int i = 0; i < 256; i++) begin
      strobe(W'($urandom), 1'b0, 1'b0);
      strobe(W'($urandom), 1'b0, 1'b0);
      handshake();
    end
    chk("wrap.zero", int'(op_count), 0);
    strobe(W'($urandom), 1'b0, 1'b0);
    strobe(W'($urandom), 1'b0, 1'b0);
    handshake();
    chk("wrap.one", int'(op_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_and_operand_loader
